// File: rtl/call_stack_sequencer.sv
// call_stack_sequencer: sequences 16-bit subroutine call/return over an
// 8-bit data memory port, keeping a descending byte stack in a dedicated page.
module call_stack_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'hFF,
  parameter logic [7:0] STACK_TOP  = 8'hFF,
  parameter int         MAX_DEPTH  = 64,
  localparam int        DW         = $clog2(MAX_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          call_req,
  input  logic          ret_req,
  input  logic [15:0]   pc,
  input  logic [15:0]   target,
  input  logic [7:0]    mem_rdata,
  output logic [15:0]   mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic          pc_load,
  output logic [15:0]   pc_next,
  output logic          busy,
  output logic          done,
  output logic [7:0]    sp,
  output logic [DW-1:0] depth,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    JUMP,
    POP_LO,
    POP_HI,
    POP_FIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] save_reg;
  logic [15:0] tgt_reg;
  logic [7:0]  lo_reg;
  logic [7:0]  sp_inc;
  logic [7:0]  sp_dec;
  logic        take_call;
  logic        set_ovf;
  logic        set_unf;

  assign sp_inc = sp + 8'd1;
  assign sp_dec = sp - 8'd1;

  // Next-state and output decode; strobes and addresses depend on state only,
  // pc_next in POP_FIN is the one output that passes mem_rdata straight through.
  always_comb begin
    state_nx  = state;
    take_call = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    pc_load   = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    pc_next   = 16'h0000;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (call_req) begin
          if (depth < MAX_D) begin
            take_call = 1'b1;
            state_nx  = PUSH_HI;
          end else begin
            set_ovf = 1'b1;
          end
        end else if (ret_req) begin
          if (depth == '0) begin
            set_unf = 1'b1;
          end else begin
            state_nx = POP_LO;
          end
        end
      end
      PUSH_HI: begin
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = save_reg[15:8];
        state_nx  = PUSH_LO;
      end
      PUSH_LO: begin
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = save_reg[7:0];
        state_nx  = JUMP;
      end
      JUMP: begin
        pc_load  = 1'b1;
        pc_next  = tgt_reg;
        done     = 1'b1;
        state_nx = IDLE;
      end
      POP_LO: begin
        mem_re   = 1'b1;
        mem_addr = {STACK_PAGE, sp_inc};
        state_nx = POP_HI;
      end
      POP_HI: begin
        mem_re   = 1'b1;
        mem_addr = {STACK_PAGE, sp_inc};
        state_nx = POP_FIN;
      end
      POP_FIN: begin
        pc_load  = 1'b1;
        pc_next  = {mem_rdata, lo_reg};
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Stack pointer, depth, sticky error flags and the saved/loaded PC bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= STACK_TOP;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      save_reg  <= 16'h0000;
      tgt_reg   <= 16'h0000;
      lo_reg    <= 8'h00;
    end else begin
      if (take_call) begin
        save_reg <= pc;
        tgt_reg  <= target;
      end
      if (set_ovf) overflow <= 1'b1;
      if (set_unf) underflow <= 1'b1;
      case (state)
        PUSH_HI: sp <= sp_dec;
        PUSH_LO: begin
          sp    <= sp_dec;
          depth <= depth + DW'(1);
        end
        POP_LO:  sp <= sp_inc;
        POP_HI: begin
          sp     <= sp_inc;
          lo_reg <= mem_rdata;
        end
        POP_FIN: depth <= depth - DW'(1);
        default: ;
      endcase
    end
  end

endmodule
